hoplite_collect: RTL and testbench

//  Return-path node of the Hoplite DDR ring. The forward switch moves DDR data (north) and west

---
 rtl/hoplite_pkg.sv | 19 +
 rtl/hoplite_fifo.sv | 45 ++++
 rtl/hoplite_collect.sv | 158 +++++++++++++++
 tb/tb_hoplite_collect.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hoplite_pkg.sv
// Types shared by the Hoplite DDR ring nodes (forward switch and return-path collector).
// Combinational definitions only: no latency, no flow control.
package hoplite_pkg;

   typedef struct packed {
      logic en_s;
      logic sel_s;
      logic sel_w;
   } sched_entry_t;

   localparam logic SRC_EAST = 1'b0;
   localparam logic SRC_PE   = 1'b1;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } run_state_t;

endpackage

// File: rtl/hoplite_fifo.sv
// First-word-fall-through FIFO: head visible combinationally, a push is readable the next cycle.
// A push into a full FIFO is only accepted when a pop happens in the same cycle.
module hoplite_fifo #(
   parameter int D_W    = 512,
   parameter int FIFO_D = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           push,
   input  logic [D_W-1:0] wdata,
   input  logic           pop,
   output logic [D_W-1:0] rdata,
   output logic           full,
   output logic           empty
);
   localparam int AW = $clog2(FIFO_D);

   logic [AW:0]    wr_ptr;
   logic [AW:0]    rd_ptr;
   logic [D_W-1:0] mem [FIFO_D];
   logic           do_push;
   logic           do_pop;

   // Extra pointer MSB tells a full FIFO from an empty one.
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/hoplite_collect.sv
// Return-path ring node: replays a select schedule, west output after 2+PIPENUM cycles, DDR FIFO
// head after 2 cycles; DDR side is valid/ready, a push into a full FIFO without a pop drops and sets ovf.
module hoplite_collect
   import hoplite_pkg::*;
#(
   parameter int D_W     = 512,
   parameter int PIPENUM = 4,
   parameter int LENGTH  = 4,
   parameter int FIFO_D  = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [D_W-1:0]            e_in,
   input  logic                      e_in_v,
   input  logic [D_W-1:0]            pe_in,
   input  logic                      pe_in_v,
   output logic [D_W-1:0]            w_out,
   output logic                      w_out_v,
   output logic [D_W-1:0]            s_out,
   output logic                      s_out_v,
   input  logic                      s_out_rdy,
   input  logic                      sched_we,
   input  logic [$clog2(LENGTH)-1:0] sched_addr,
   input  logic [2:0]                sched_data,
   input  logic                      start,
   output logic                      busy,
   output logic                      done,
   output logic                      ovf
);
   localparam int CW = $clog2(LENGTH);

   logic [D_W-1:0] e_q, pe_q;
   logic           e_v_q, pe_v_q;
   sched_entry_t   sched [LENGTH];
   sched_entry_t   ent;
   run_state_t     state_q, state_d;
   logic [CW-1:0]  cyc_q, cyc_d;
   logic           started_q, done_q, ovf_q;
   logic [D_W-1:0] w_sel_dat, s_sel_dat, w_mux_dat;
   logic           w_sel_vld, s_sel_vld, w_mux_vld;
   logic           push, pop, fifo_full, fifo_empty;
   logic [D_W-1:0] pipe_dat [PIPENUM+1];
   logic           pipe_vld [PIPENUM+1];

   assign busy = (state_q == RUN);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         e_q    <= '0;
         pe_q   <= '0;
         e_v_q  <= 1'b0;
         pe_v_q <= 1'b0;
      end else begin
         e_q    <= e_in;
         pe_q   <= pe_in;
         e_v_q  <= e_in_v;
         pe_v_q <= pe_in_v;
      end
   end

   // Schedule RAM keeps its contents across reset.
   always_ff @(posedge clk) begin
      if (sched_we && !busy && (int'(sched_addr) < LENGTH))
         sched[sched_addr] <= sched_entry_t'(sched_data);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cyc_q   <= '0;
      end else begin
         state_q <= state_d;
         cyc_q   <= cyc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cyc_d   = cyc_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               cyc_d   = '0;
            end
         end
         RUN: begin
            if (cyc_q == CW'(LENGTH-1)) state_d = IDLE;
            else                        cyc_d   = cyc_q + CW'(1);
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ent       = sched[cyc_q];
      w_sel_dat = (ent.sel_w == SRC_PE) ? pe_q   : e_q;
      w_sel_vld = (ent.sel_w == SRC_PE) ? pe_v_q : e_v_q;
      s_sel_dat = (ent.sel_s == SRC_PE) ? pe_q   : e_q;
      s_sel_vld = (ent.sel_s == SRC_PE) ? pe_v_q : e_v_q;
      w_mux_dat = busy ? w_sel_dat : '0;
      w_mux_vld = busy && w_sel_vld;
      push      = busy && ent.en_s && s_sel_vld;
   end

   // Stage 0 is the w_out register; PIPENUM stages follow it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i <= PIPENUM; i++) begin
            pipe_dat[i] <= '0;
            pipe_vld[i] <= 1'b0;
         end
      end else begin
         pipe_dat[0] <= w_mux_dat;
         pipe_vld[0] <= w_mux_vld;
         for (int i = 1; i <= PIPENUM; i++) begin
            pipe_dat[i] <= pipe_dat[i-1];
            pipe_vld[i] <= pipe_vld[i-1];
         end
      end
   end

   assign w_out   = pipe_dat[PIPENUM];
   assign w_out_v = pipe_vld[PIPENUM];

   hoplite_fifo #(.D_W(D_W), .FIFO_D(FIFO_D)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata (s_sel_dat),
      .pop   (pop),
      .rdata (s_out),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign s_out_v = !fifo_empty;
   assign pop     = s_out_v && s_out_rdy;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         started_q <= 1'b0;
         done_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else if (start && !busy) begin
         started_q <= 1'b1;
         done_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         if (!busy && started_q && fifo_empty) done_q <= 1'b1;
         if (push && fifo_full && !pop)        ovf_q  <= 1'b1;
      end
   end

   assign done = done_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_hoplite_collect.sv
// Directed bench for hoplite_collect: inputs driven and outputs checked on the falling edge.
module tb_hoplite_collect;
   localparam int D_W     = 32;
   localparam int PIPENUM = 4;
   localparam int LENGTH  = 6;
   localparam int FIFO_D  = 4;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [D_W-1:0] e_in = '0;
   logic           e_in_v = 1'b0;
   logic [D_W-1:0] pe_in = '0;
   logic           pe_in_v = 1'b0;
   logic [D_W-1:0] w_out;
   logic           w_out_v;
   logic [D_W-1:0] s_out;
   logic           s_out_v;
   logic           s_out_rdy = 1'b0;
   logic           sched_we = 1'b0;
   logic [2:0]     sched_addr = '0;
   logic [2:0]     sched_data = '0;
   logic           start = 1'b0;
   logic           busy, done, ovf;

   int errors = 0;
   int checks = 0;

   hoplite_collect #(.D_W(D_W), .PIPENUM(PIPENUM), .LENGTH(LENGTH), .FIFO_D(FIFO_D)) dut (
      .clk        (clk),
      .rst        (rst),
      .e_in       (e_in),
      .e_in_v     (e_in_v),
      .pe_in      (pe_in),
      .pe_in_v    (pe_in_v),
      .w_out      (w_out),
      .w_out_v    (w_out_v),
      .s_out      (s_out),
      .s_out_v    (s_out_v),
      .s_out_rdy  (s_out_rdy),
      .sched_we   (sched_we),
      .sched_addr (sched_addr),
      .sched_data (sched_data),
      .start      (start),
      .busy       (busy),
      .done       (done),
      .ovf        (ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [D_W-1:0] obs, input logic [D_W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input int a, input logic [2:0] d);
      sched_we   = 1'b1;
      sched_addr = 3'(a);
      sched_data = d;
      @(negedge clk);
      sched_we   = 1'b0;
   endtask

   task automatic load_all(input logic [2:0] d);
      for (int a = 0; a < LENGTH; a++) wr(a, d);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      @(negedge clk);
      @(negedge clk);
      chk("rst_w_out_v", w_out_v, 0);
      chk("rst_w_out", w_out, 0);
      chk("rst_s_out_v", s_out_v, 0);
      chk("rst_s_out", s_out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ovf", ovf, 0);
      rst = 1'b0;
      @(negedge clk);

      // 1: PE stream to the west only
      load_all(3'b001);
      for (int n = 0; n <= 11; n++) begin
         if (n == 1) chk("t1_busy", busy, 1);
         if (n == 2) chk("t1_s_out_v", s_out_v, 0);
         if (n >= 6 && n <= 9) begin
            chk("t1_w_out", w_out, 32'hA0 + 32'(n - 6));
            chk("t1_w_out_v", w_out_v, 1);
         end
         if (n == 10) chk("t1_w_out_v_end", w_out_v, 0);
         if (n == 11) begin
            chk("t1_busy_end", busy, 0);
            chk("t1_done", done, 1);
            chk("t1_s_out_v_end", s_out_v, 0);
         end
         start   = (n == 0);
         pe_in   = 32'hA0 + 32'(n);
         pe_in_v = (n < 4);
         @(negedge clk);
      end

      // 2: east to west, PE to DDR, writer always ready
      load_all(3'b110);
      s_out_rdy = 1'b1;
      for (int n = 0; n <= 11; n++) begin
         if (n == 1) chk("t2_done_clr", done, 0);
         if (n >= 2 && n <= 5) begin
            chk("t2_s_out", s_out, 32'hB0 + 32'(n - 2));
            chk("t2_s_out_v", s_out_v, 1);
         end
         if (n == 6) chk("t2_s_out_v_end", s_out_v, 0);
         if (n >= 6 && n <= 9) chk("t2_w_out", w_out, 32'hE0 + 32'(n - 6));
         if (n == 11) begin
            chk("t2_done", done, 1);
            chk("t2_ovf", ovf, 0);
         end
         start   = (n == 0);
         e_in    = 32'hE0 + 32'(n);
         pe_in   = 32'hB0 + 32'(n);
         e_in_v  = (n < 4);
         pe_in_v = (n < 4);
         @(negedge clk);
      end

      // 3: writer stalled, FIFO overflows, then drains
      for (int n = 0; n <= 13; n++) begin
         if (n == 5) begin
            chk("t3_ovf_pre", ovf, 0);
            chk("t3_head_full", s_out, 32'hB0);
         end
         if (n == 6) chk("t3_ovf", ovf, 1);
         if (n >= 8 && n <= 11) chk("t3_drain", s_out, 32'hB0 + 32'(n - 8));
         if (n == 12) begin
            chk("t3_empty", s_out_v, 0);
            chk("t3_done_pre", done, 0);
         end
         if (n == 13) begin
            chk("t3_done", done, 1);
            chk("t3_ovf_sticky", ovf, 1);
         end
         start     = (n == 0);
         e_in      = 32'hE0 + 32'(n);
         pe_in     = 32'hB0 + 32'(n);
         e_in_v    = (n < 6);
         pe_in_v   = (n < 6);
         s_out_rdy = (n >= 8);
         @(negedge clk);
      end

      // 4: push and pop together while full
      for (int n = 0; n <= 11; n++) begin
         if (n >= 5 && n <= 10) chk("t4_order", s_out, 32'hC0 + 32'(n - 5));
         if (n == 7) chk("t4_ovf", ovf, 0);
         if (n == 11) begin
            chk("t4_empty", s_out_v, 0);
            chk("t4_ovf_end", ovf, 0);
         end
         start     = (n == 0);
         pe_in     = 32'hC0 + 32'(n);
         pe_in_v   = (n < 6);
         e_in_v    = 1'b0;
         s_out_rdy = (n >= 5);
         @(negedge clk);
      end

      // 5: reset mid-run, then replay from entry 0
      wr(0, 3'b111);
      for (int a = 1; a < LENGTH; a++) wr(a, 3'b110);
      for (int n = 0; n <= 2; n++) begin
         start     = (n == 0);
         pe_in     = 32'hD0 + 32'(n);
         e_in      = 32'hF0 + 32'(n);
         pe_in_v   = 1'b1;
         e_in_v    = 1'b1;
         s_out_rdy = 1'b0;
         @(negedge clk);
      end
      chk("t5_busy_pre", busy, 1);
      chk("t5_s_out_v_pre", s_out_v, 1);
      start   = 1'b0;
      pe_in_v = 1'b0;
      e_in_v  = 1'b0;
      rst     = 1'b1;
      #1;
      chk("t5_busy", busy, 0);
      chk("t5_w_out_v", w_out_v, 0);
      chk("t5_s_out_v", s_out_v, 0);
      chk("t5_done", done, 0);
      chk("t5_ovf", ovf, 0);
      @(negedge clk);
      rst = 1'b0;
      for (int n = 0; n <= 7; n++) begin
         chk("t5_no_partial", w_out_v, 0);
         @(negedge clk);
      end
      for (int n = 0; n <= 7; n++) begin
         if (n == 2) chk("t5_s_entry0", s_out, 32'h90);
         if (n == 3) chk("t5_s_entry1", s_out, 32'h91);
         if (n == 6) chk("t5_w_entry0", w_out, 32'h90);
         if (n == 7) chk("t5_w_entry1", w_out, 32'h81);
         start     = (n == 0);
         pe_in     = 32'h90 + 32'(n);
         e_in      = 32'h80 + 32'(n);
         pe_in_v   = (n < 2);
         e_in_v    = (n < 2);
         s_out_rdy = 1'b1;
         @(negedge clk);
      end

      // 6: schedule write and start while busy are ignored
      load_all(3'b001);
      for (int n = 0; n <= 11; n++) begin
         if (n == 7) chk("t6_busy", busy, 0);
         if (n == 8) chk("t6_done", done, 1);
         if (n >= 6 && n <= 11) chk("t6_w_out", w_out, 32'h60 + 32'(n - 6));
         start      = (n == 0 || n == 2);
         sched_we   = (n == 2);
         sched_addr = 3'd4;
         sched_data = 3'b000;
         pe_in      = 32'h60 + 32'(n);
         e_in       = 32'h70 + 32'(n);
         pe_in_v    = (n < 6);
         e_in_v     = (n < 6);
         @(negedge clk);
      end
      sched_we = 1'b0;
      start    = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
